sata_platform_oob: RTL and testbench

//  Parametrised OOB sequencer/detector and link-ready tracker between the SATA PHY layer and transceiver.

---
 rtl/sata_platform_oob_pkg.sv | 20 ++
 rtl/sata_oob_rx_detect.sv | 75 +++++++
 rtl/sata_platform_oob.sv | 190 +++++++++++++++++++
 tb/tb_sata_platform_oob.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sata_platform_oob_pkg.sv
// Shared constants for the SATA OOB sequencer: ALIGN primitive, K-flag pattern
// and the TX / READY state encodings.
package sata_platform_oob_pkg;

    localparam logic [31:0] ALIGN_PRIM  = 32'h7B4A4ABC;
    localparam logic [3:0]  ALIGN_ISK32 = 4'b0001;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_BURST = 2'd1;
    localparam logic [1:0] TX_GAP   = 2'd2;

    localparam logic [1:0] RDY_WAIT_PLL = 2'd0;
    localparam logic [1:0] RDY_HUNT     = 2'd1;
    localparam logic [1:0] RDY_READY    = 2'd2;

    function automatic logic in_window(input int cnt, input int center, input int tol);
        return (cnt >= center - tol) && (cnt <= center + tol);
    endfunction

endpackage

// File: rtl/sata_oob_rx_detect.sv
// Received OOB detector: measures squelch idle gaps, classifies them as
// COMINIT or COMWAKE spacing and emits a single detect pulse per run.
module sata_oob_rx_detect
    import sata_platform_oob_pkg::*;
#(
    parameter int INIT_GAP_CYCLES = 24,
    parameter int WAKE_GAP_CYCLES = 8,
    parameter int GAP_TOL         = 2,
    parameter int DET_GAPS        = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_elec_idle,
    output logic comm_init_detect,
    output logic comm_wake_detect
);

    localparam int SAT = INIT_GAP_CYCLES + GAP_TOL + 1;
    localparam int CW  = $clog2(SAT + 1);
    localparam int DW  = $clog2(DET_GAPS + 1);

    logic [CW-1:0] idle_cnt;
    logic [DW-1:0] init_cnt;
    logic [DW-1:0] wake_cnt;
    logic          gap_end;
    logic          sat;
    logic          init_hit;
    logic          wake_hit;

    // idle_cnt is only non-zero after idle cycles, so this marks the 1->0 edge
    assign gap_end  = !rx_elec_idle && (idle_cnt != '0);
    assign sat      = (idle_cnt == CW'(SAT));
    assign init_hit = gap_end && in_window(int'(idle_cnt), INIT_GAP_CYCLES, GAP_TOL);
    assign wake_hit = gap_end && !init_hit && in_window(int'(idle_cnt), WAKE_GAP_CYCLES, GAP_TOL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (rx_elec_idle) begin
            if (!sat) idle_cnt <= idle_cnt + 1'b1;
        end else begin
            idle_cnt <= '0;
        end
    end

    // Counts saturate at DET_GAPS so a run pulses once until it is broken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt         <= '0;
            wake_cnt         <= '0;
            comm_init_detect <= 1'b0;
            comm_wake_detect <= 1'b0;
        end else begin
            comm_init_detect <= 1'b0;
            comm_wake_detect <= 1'b0;
            if (sat || (gap_end && !init_hit && !wake_hit)) begin
                init_cnt <= '0;
                wake_cnt <= '0;
            end else if (init_hit) begin
                wake_cnt <= '0;
                if (init_cnt != DW'(DET_GAPS)) begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == DW'(DET_GAPS - 1)) comm_init_detect <= 1'b1;
                end
            end else if (wake_hit) begin
                init_cnt <= '0;
                if (wake_cnt != DW'(DET_GAPS)) begin
                    wake_cnt <= wake_cnt + 1'b1;
                    if (wake_cnt == DW'(DET_GAPS - 1)) comm_wake_detect <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sata_platform_oob.sv
// SATA platform OOB sequencer, OOB detector wrapper and link-ready tracker.
// Optional macro SATA_ALIGN_LOSS_EN: drop ready after ALIGN_LOSS bad cycles.
module sata_platform_oob
    import sata_platform_oob_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int BURST_CYCLES    = 8,
    parameter int INIT_GAP_CYCLES = 24,
    parameter int WAKE_GAP_CYCLES = 8,
    parameter int BURST_COUNT     = 6,
    parameter int GAP_TOL         = 2,
    parameter int DET_GAPS        = 3,
    parameter int ALIGN_LOCK      = 4,
    parameter int ALIGN_LOSS      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tx_comm_reset,
    input  logic                    tx_comm_wake,
    output logic                    tx_oob_busy,
    output logic                    tx_elec_idle,
    input  logic                    rx_elec_idle,
    output logic                    comm_init_detect,
    output logic                    comm_wake_detect,
    input  logic                    rx_byte_is_aligned,
    input  logic [DATA_WIDTH-1:0]   phy_rx_din,
    input  logic [DATA_WIDTH/8-1:0] phy_rx_isk,
    input  logic                    pll_locked,
    output logic                    platform_ready
);

    localparam int TX_SPAN = (INIT_GAP_CYCLES > WAKE_GAP_CYCLES) ? INIT_GAP_CYCLES : WAKE_GAP_CYCLES;
    localparam int TX_MAX  = (TX_SPAN > BURST_CYCLES) ? TX_SPAN : BURST_CYCLES;
    localparam int TX_CW   = $clog2(TX_MAX + 1);
    localparam int BC_W    = $clog2(BURST_COUNT + 1);
    localparam int AL_W    = $clog2(ALIGN_LOCK + 1);

    logic [1:0]       tx_state;
    logic [TX_CW-1:0] tx_cnt;
    logic [TX_CW-1:0] gap_len;
    logic [BC_W-1:0]  burst_idx;
    logic             tx_start;
    logic             reset_accept;

    logic [1:0]       rdy_state;
    logic [AL_W-1:0]  align_cnt;
    logic             align_pair;
    logic             align_hold;
    logic             loss_drop;

    assign tx_start     = (tx_state == TX_IDLE) && (tx_comm_reset || tx_comm_wake);
    assign reset_accept = (tx_state == TX_IDLE) && tx_comm_reset;
    assign tx_oob_busy  = (tx_state != TX_IDLE);
    assign tx_elec_idle = (tx_state != TX_BURST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            gap_len   <= '0;
            burst_idx <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_start) begin
                        tx_state  <= TX_BURST;
                        tx_cnt    <= '0;
                        burst_idx <= '0;
                        gap_len   <= tx_comm_reset ? TX_CW'(INIT_GAP_CYCLES) : TX_CW'(WAKE_GAP_CYCLES);
                    end
                end
                TX_BURST: begin
                    if (tx_cnt == TX_CW'(BURST_CYCLES - 1)) begin
                        tx_state <= TX_GAP;
                        tx_cnt   <= '0;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_GAP: begin
                    if (tx_cnt == gap_len - 1'b1) begin
                        tx_cnt <= '0;
                        if (burst_idx == BC_W'(BURST_COUNT - 1)) begin
                            tx_state <= TX_IDLE;
                        end else begin
                            tx_state  <= TX_BURST;
                            burst_idx <= burst_idx + 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // align_pair advances the lock count; align_hold keeps it (16b first half)
    generate
        if (DATA_WIDTH == 32) begin : g_align32
            assign align_pair = rx_byte_is_aligned && (phy_rx_din == ALIGN_PRIM)
                                && (phy_rx_isk == ALIGN_ISK32);
            assign align_hold = 1'b0;
        end else begin : g_align16
            logic half_seen;
            logic lo_hit;
            logic hi_hit;
            assign lo_hit = rx_byte_is_aligned && (phy_rx_din == ALIGN_PRIM[15:0])
                            && (phy_rx_isk == ALIGN_ISK32[1:0]);
            assign hi_hit = rx_byte_is_aligned && (phy_rx_din == ALIGN_PRIM[31:16])
                            && (phy_rx_isk == ALIGN_ISK32[3:2]);
            assign align_pair = hi_hit && half_seen;
            assign align_hold = lo_hit && !half_seen;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) half_seen <= 1'b0;
                else     half_seen <= lo_hit;
            end
        end
    endgenerate

`ifdef SATA_ALIGN_LOSS_EN
    localparam int LW = $clog2(ALIGN_LOSS + 1);
    logic [LW-1:0] loss_cnt;
    logic          loss_bad;

    assign loss_bad  = !rx_byte_is_aligned || rx_elec_idle;
    assign loss_drop = (rdy_state == RDY_READY) && loss_bad && (loss_cnt == LW'(ALIGN_LOSS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                        loss_cnt <= '0;
        else if (rdy_state != RDY_READY || !loss_bad)   loss_cnt <= '0;
        else if (loss_drop)                             loss_cnt <= '0;
        else                                            loss_cnt <= loss_cnt + 1'b1;
    end
`else
    assign loss_drop = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_state <= RDY_WAIT_PLL;
            align_cnt <= '0;
        end else if (!pll_locked) begin
            rdy_state <= RDY_WAIT_PLL;
            align_cnt <= '0;
        end else if (reset_accept) begin
            rdy_state <= RDY_HUNT;
            align_cnt <= '0;
        end else begin
            case (rdy_state)
                RDY_WAIT_PLL: begin
                    rdy_state <= RDY_HUNT;
                    align_cnt <= '0;
                end
                RDY_HUNT: begin
                    if (align_pair) begin
                        if (align_cnt == AL_W'(ALIGN_LOCK - 1)) begin
                            rdy_state <= RDY_READY;
                            align_cnt <= '0;
                        end else begin
                            align_cnt <= align_cnt + 1'b1;
                        end
                    end else if (!align_hold) begin
                        align_cnt <= '0;
                    end
                end
                RDY_READY: begin
                    if (loss_drop) rdy_state <= RDY_HUNT;
                end
                default: rdy_state <= RDY_WAIT_PLL;
            endcase
        end
    end

    assign platform_ready = (rdy_state == RDY_READY);

    sata_oob_rx_detect #(
        .INIT_GAP_CYCLES (INIT_GAP_CYCLES),
        .WAKE_GAP_CYCLES (WAKE_GAP_CYCLES),
        .GAP_TOL         (GAP_TOL),
        .DET_GAPS        (DET_GAPS)
    ) u_rx_detect (
        .clk              (clk),
        .rst              (rst),
        .rx_elec_idle     (rx_elec_idle),
        .comm_init_detect (comm_init_detect),
        .comm_wake_detect (comm_wake_detect)
    );

endmodule

// File: tb/tb_sata_platform_oob.sv
// Directed bench for sata_platform_oob: TX trains, RX gap classification and
// ready tracking; detect pulses are matched against a queue of expected events.
module tb_sata_platform_oob;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_comm_reset;
    logic        tx_comm_wake;
    logic        tx_oob_busy;
    logic        tx_elec_idle;
    logic        rx_elec_idle;
    logic        comm_init_detect;
    logic        comm_wake_detect;
    logic        rx_byte_is_aligned;
    logic [31:0] phy_rx_din;
    logic [3:0]  phy_rx_isk;
    logic        pll_locked;
    logic        platform_ready;

`ifdef SATA_ALIGN_LOSS_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    localparam logic [31:0] ALIGN = 32'h7B4A4ABC;
    localparam logic [1:0]  EXP_INIT = 2'b10;
    localparam logic [1:0]  EXP_WAKE = 2'b01;

    int n_assert = 0;
    int n_fail   = 0;
    logic [1:0] exp_q[$];

    sata_platform_oob dut (
        .clk                (clk),
        .rst                (rst),
        .tx_comm_reset      (tx_comm_reset),
        .tx_comm_wake       (tx_comm_wake),
        .tx_oob_busy        (tx_oob_busy),
        .tx_elec_idle       (tx_elec_idle),
        .rx_elec_idle       (rx_elec_idle),
        .comm_init_detect   (comm_init_detect),
        .comm_wake_detect   (comm_wake_detect),
        .rx_byte_is_aligned (rx_byte_is_aligned),
        .phy_rx_din         (phy_rx_din),
        .phy_rx_isk         (phy_rx_isk),
        .pll_locked         (pll_locked),
        .platform_ready     (platform_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every detect pulse must match the oldest queued expectation
    always @(negedge clk) begin
        logic [1:0] e;
        if (rst === 1'b0 && (comm_init_detect || comm_wake_detect)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_detect", {30'b0, comm_init_detect, comm_wake_detect}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("detect_kind", {30'b0, comm_init_detect, comm_wake_detect}, {30'b0, e});
            end
        end
    end

    task automatic rx_gap(input int n);
        rx_elec_idle = 1'b1;
        repeat (n) @(negedge clk);
        rx_elec_idle = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] din, input logic [3:0] isk, input logic al,
                         input logic exp_ready, input string tag);
        phy_rx_din = din;
        phy_rx_isk = isk;
        rx_byte_is_aligned = al;
        @(negedge clk);
        check(tag, platform_ready, exp_ready);
    endtask

    task automatic run_train(input int gap, input bit inject_wake, input string tag);
        for (int b = 0; b < 6; b++) begin
            for (int c = 0; c < 8 + gap; c++) begin
                check({tag, "_elec_idle"}, tx_elec_idle, c >= 8);
                check({tag, "_busy"}, tx_oob_busy, 1'b1);
                tx_comm_wake = inject_wake && b == 2 && c == 3;
                @(negedge clk);
            end
        end
        tx_comm_wake = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check({tag, "_done_busy"}, tx_oob_busy, 1'b0);
            check({tag, "_done_idle"}, tx_elec_idle, 1'b1);
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        tx_comm_reset = 1'b0;
        tx_comm_wake = 1'b0;
        rx_elec_idle = 1'b1;
        rx_byte_is_aligned = 1'b0;
        phy_rx_din = '0;
        phy_rx_isk = '0;
        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_elec_idle", tx_elec_idle, 1'b1);
        check("rst_busy", tx_oob_busy, 1'b0);
        check("rst_ready", platform_ready, 1'b0);
        check("rst_init_det", comm_init_detect, 1'b0);
        check("rst_wake_det", comm_wake_detect, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // COMINIT: 25,23,24 pulse once; a fourth in-class gap does not re-pulse
        rx_gap(30);
        rx_gap(25);
        rx_gap(23);
        exp_q.push_back(EXP_INIT);
        rx_gap(24);
        rx_gap(24);
        check("init_pulse_seen", exp_q.size(), 0);
        // COMWAKE: 8,8,15 breaks the run; 8,8,8 pulses once
        rx_gap(30);
        rx_gap(8);
        rx_gap(8);
        rx_gap(15);
        rx_gap(8);
        rx_gap(8);
        exp_q.push_back(EXP_WAKE);
        rx_gap(8);
        check("wake_pulse_seen", exp_q.size(), 0);
        // Window edges: 22/26 and 6/10 accepted, 21 and 11 break the run
        rx_gap(30);
        rx_gap(22);
        rx_gap(26);
        rx_gap(21);
        rx_gap(6);
        rx_gap(10);
        rx_gap(11);
        rx_gap(26);
        rx_gap(22);
        exp_q.push_back(EXP_INIT);
        rx_gap(26);
        rx_gap(6);
        rx_gap(10);
        exp_q.push_back(EXP_WAKE);
        rx_gap(10);
        check("edge_pulses_seen", exp_q.size(), 0);

        // Ready: a broken ALIGN run restarts the lock count
        pll_locked = 1'b1;
        @(negedge clk);
        check("hunt_ready", platform_ready, 1'b0);
        for (int i = 0; i < 3; i++) drive(ALIGN, 4'b0001, 1'b1, 1'b0, "lock_a");
        drive(ALIGN, 4'b0011, 1'b1, 1'b0, "lock_bad_isk");
        for (int i = 0; i < 3; i++) drive(ALIGN, 4'b0001, 1'b1, 1'b0, "lock_b");
        drive(ALIGN, 4'b0001, 1'b0, 1'b0, "lock_unaligned");
        for (int i = 0; i < 3; i++) drive(ALIGN, 4'b0001, 1'b1, 1'b0, "lock_c");
        drive(ALIGN, 4'b0001, 1'b1, 1'b1, "lock_done");
        drive(ALIGN, 4'b0001, 1'b1, 1'b1, "ready_hold");

        pll_locked = 1'b0;
        drive(ALIGN, 4'b0001, 1'b1, 1'b0, "pll_drop");
        pll_locked = 1'b1;
        drive(ALIGN, 4'b0001, 1'b1, 1'b0, "pll_back");
        for (int i = 0; i < 3; i++) drive(ALIGN, 4'b0001, 1'b1, 1'b0, "relock");
        drive(ALIGN, 4'b0001, 1'b1, 1'b1, "relock_done");

        // Loss window: 7 bad then good keeps ready; 8 bad drops it when enabled
        for (int i = 0; i < 7; i++) drive(ALIGN, 4'b0001, 1'b0, 1'b1, "loss7");
        drive(ALIGN, 4'b0001, 1'b1, 1'b1, "loss7_good");
        for (int i = 0; i < 8; i++)
            drive(ALIGN, 4'b0001, 1'b0, (i < 7) ? 1'b1 : !LOSS_EN, "loss8");
        drive('0, 4'b0000, 1'b1, !LOSS_EN, "loss_after");

        // COMRESET train; accepting it also sends READY back to HUNT
        tx_comm_reset = 1'b1;
        @(negedge clk);
        tx_comm_reset = 1'b0;
        check("comreset_ready_drop", platform_ready, 1'b0);
        run_train(24, 1'b0, "comreset");

        // Simultaneous requests: COMRESET wins; a mid-train wake is dropped
        tx_comm_reset = 1'b1;
        tx_comm_wake = 1'b1;
        @(negedge clk);
        tx_comm_reset = 1'b0;
        tx_comm_wake = 1'b0;
        run_train(24, 1'b1, "both");

        tx_comm_wake = 1'b1;
        @(negedge clk);
        tx_comm_wake = 1'b0;
        run_train(8, 1'b0, "comwake");

        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
